// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: bus widths, controller
// states, load/store size codes, the default IO window base, and a helper
// that turns a size code into a byte count.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Load/store size codes; code 11 behaves as a full word.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a
// load/store port onto a single 8-bit RAM with one cycle of read latency.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rdy                 global enable, low freezes the controller
//   io_buffer_full      IO sink back-pressure for stores at/above IO_BASE
//   ic_req/ic_addr      word fetch request; ic_done/ic_instr completion
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata
//                       load/store request; ls_done/ls_rdata completion
//   mem_din             RAM read byte (one cycle after mem_a)
//   mem_dout/mem_a/mem_wr
//                       RAM write byte, byte address, write strobe
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               io_buffer_full,
  input  logic               ic_req,
  input  logic [ADDR_W-1:0]  ic_addr,
  output logic               ic_done,
  output logic [INSTR_W-1:0] ic_instr,
  input  logic               ls_req,
  input  logic               ls_wr,
  input  logic [1:0]         ls_size,
  input  logic [ADDR_W-1:0]  ls_addr,
  input  logic [31:0]        ls_wdata,
  output logic               ls_done,
  output logic [31:0]        ls_rdata,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [ADDR_W-1:0]  mem_a,
  output logic               mem_wr
);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q;
  logic               is_ls;
  logic [2:0]         cyc;       // read: edges since issue; write: byte index
  logic [31:0]        asm_q;
  logic               restart;   // a read was frozen; re-issue from byte 0

  logic [2:0]         nb;
  logic               io_block;
  logic               rd_last;
  logic               wr_last;
  logic [1:0]         rd_lane;
  logic [1:0]         wr_lane;
  logic [31:0]        rd_word;

  assign nb       = nbytes(size_q);
  assign io_block = (state == WRITE) && (addr_q >= IO_BASE) && io_buffer_full;
  // The byte captured at this edge was addressed two edges ago, so the
  // lane index trails the counter by one.
  assign rd_lane  = 2'(cyc - 3'd1);
  assign wr_lane  = 2'(cyc + 3'd1);
  assign rd_last  = (state == READ) && !restart && (cyc == nb);
  assign wr_last  = (state == WRITE) && !io_block && ((cyc + 3'd1) == nb);

  always_comb begin
    rd_word = asm_q;
    if (cyc != 3'd0) rd_word[{rd_lane, 3'b000} +: 8] = mem_din;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (rdy) begin
      case (state)
        IDLE: begin
          if (ls_req)      state_nx = ls_wr ? WRITE : READ;
          else if (ic_req) state_nx = READ;
        end
        READ:    if (rd_last) state_nx = DONE;
        WRITE:   if (wr_last) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs; done is gated by rdy so a frozen DONE cycle does not stretch
  // the pulse seen by the requester.
  always_comb begin
    mem_wr  = (state == WRITE) && rdy && !io_block;
    ic_done = (state == DONE) && rdy && !is_ls;
    ls_done = (state == DONE) && rdy && is_ls;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      is_ls    <= 1'b0;
      cyc      <= '0;
      asm_q    <= '0;
      restart  <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      ic_instr <= '0;
      ls_rdata <= '0;
    end else if (!rdy) begin
      // The RAM keeps answering while frozen, so the read pipeline loses
      // sync; remember to re-issue once the enable returns.
      if (state == READ) restart <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (ls_req) begin
            addr_q   <= ls_addr;
            size_q   <= ls_size;
            wdata_q  <= ls_wdata;
            is_ls    <= 1'b1;
            mem_a    <= ls_addr;
            mem_dout <= ls_wdata[7:0];
            cyc      <= '0;
            asm_q    <= '0;
            restart  <= 1'b0;
          end else if (ic_req) begin
            addr_q   <= ic_addr;
            size_q   <= SIZE_W;
            is_ls    <= 1'b0;
            mem_a    <= ic_addr;
            cyc      <= '0;
            asm_q    <= '0;
            restart  <= 1'b0;
          end
        end
        READ: begin
          if (restart) begin
            restart <= 1'b0;
            mem_a   <= addr_q;
            cyc     <= '0;
            asm_q   <= '0;
          end else begin
            asm_q <= rd_word;
            if (rd_last) begin
              if (is_ls) ls_rdata <= rd_word;
              else       ic_instr <= rd_word;
            end else begin
              cyc <= cyc + 3'd1;
              if ((cyc + 3'd1) < nb) mem_a <= addr_q + ADDR_W'(cyc) + 32'd1;
            end
          end
        end
        WRITE: begin
          if (!io_block && !wr_last) begin
            cyc      <= cyc + 3'd1;
            mem_a    <= addr_q + ADDR_W'(cyc) + 32'd1;
            mem_dout <= wdata_q[{wr_lane, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000, meaning the lowest address in memory-mapped IO space.
REQ-002 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy  input  1  global enable; low freezes the block.
REQ-005 SHALL have port io_buffer_full  input  1  IO write sink cannot accept a byte.
REQ-006 SHALL have port ic_req  input  1  ICache word-fetch request, held until ic_done.
REQ-007 SHALL have port ic_addr  input  32  fetch byte address.
REQ-008 SHALL have port ic_done  output  1  fetch complete, one-cycle pulse.
REQ-009 SHALL have port ic_instr  output  32  fetched word, valid while ic_done is high.
REQ-010 SHALL have port ls_req  input  1  load/store request, held until ls_done.
REQ-011 SHALL have port ls_wr  input  1  1 = store, 0 = load.
REQ-012 SHALL have port ls_size  input  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes (11 = 4).
REQ-013 SHALL have port ls_addr  input  32  byte address.
REQ-014 SHALL have port ls_wdata  input  32  store data, low bytes first.
REQ-015 SHALL have port ls_done  output  1  load/store complete, one-cycle pulse.
REQ-016 SHALL have port ls_rdata  output  32  load data, zero-extended, valid while ls_done is high.
REQ-017 SHALL have port mem_din  input  8  RAM read byte.
REQ-018 SHALL have port mem_dout  output  8  RAM write byte.
REQ-019 SHALL have port mem_a  output  32  RAM byte address.
REQ-020 SHALL have port mem_wr  output  1  1 = write mem_dout to mem_a this cycle.

Function
REQ-021 SHALL implement states IDLE, READ, WRITE and DONE; requests SHALL be sampled only in IDLE.
REQ-022 SHALL accept ls_req over ic_req when both are high in IDLE, and SHALL NOT preempt a transaction once it is accepted.
REQ-023 SHALL latch the request's address, size, wdata and requester on the accepting edge E0.
REQ-024 SHALL, for a read, drive mem_a = addr+k for byte k after edge E(k) and capture mem_din into byte lane k at edge E(k+2), since RAM read latency is one cycle.
REQ-025 SHALL move to DONE after the last byte capture; a word fetch SHALL show done high in the cycle after E5.
REQ-026 SHALL, for a store, drive mem_wr=1, mem_a=addr+k and mem_dout=wdata[8k+7:8k] after edge E(k), for k = 0 up to size-1, then enter DONE.
REQ-027 SHALL, for a store with addr >= IO_BASE, hold mem_wr=0 and not advance k while io_buffer_full is high.
REQ-028 SHALL, in DONE, assert exactly the requester's done signal for one cycle with data stable, then move to IDLE unconditionally.
REQ-029 Requesters SHALL deassert or replace req by the edge ending the DONE cycle; the block SHALL NOT re-accept a request during DONE.
REQ-030 SHALL assemble bytes little-endian, and unused upper lanes of ls_rdata SHALL be 0.
REQ-031 SHALL wrap address arithmetic modulo 2^32 (addr FFFF_FFFE + 2 = 0000_0000).
REQ-032 SHALL, while rdy is low, hold all registers and force mem_wr=0.
REQ-033 SHALL, on rdy returning high, restart an in-progress read from byte 0 and resume an in-progress store at the current k.
REQ-034 SHALL drive mem_wr=0 in IDLE and DONE, with mem_a holding its last value.

Reset
REQ-035 SHALL, on rst low and regardless of clk, immediately go to IDLE with ic_done=0, ls_done=0, mem_wr=0, mem_a=0, mem_dout=0, ic_instr=0 and ls_rdata=0.
REQ-036 SHALL, on reset mid-transaction, abandon the transaction with no done pulse, and the requester SHALL re-issue it.

Structure
REQ-037 SHALL take the ADDR and INSTRLEN width macros, the state encodings, the size codes and IO_BASE from the shared define.v.
REQ-038 SHALL be one flat module with no sub-module; the byte counter and assembly register SHALL be local.

Verification
REQ-039 Bench SHALL check: word fetch at 0x100 with RAM bytes 13,05,00,00 -> ic_done in the cycle after E5 with ic_instr=0x0000_0513.
REQ-040 Bench SHALL check: ic_req and ls_req (load, size 01, addr 0x20, bytes AA,BB) both high -> ls_done with ls_rdata=0x0000_BBAA first, then the fetch.
REQ-041 Bench SHALL check: store size 10, addr 0x40, data 0xDEADBEEF -> writes EF,BE,AD,DE to 0x40..0x43, then ls_done.
REQ-042 Bench SHALL check: store byte to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those cycles, then one write, then ls_done.
REQ-043 Bench SHALL check: rst low after the 2nd byte of a fetch -> all outputs 0 at once, no ic_done, and a re-issued fetch completes correctly.
REQ-044 Bench SHALL check: rdy low for 2 cycles during a fetch -> mem_wr=0, the read restarts from byte 0 and ic_instr is correct.
